// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: funct3 codes, FSM states and access-size decode shared by the MEM-stage LSU.
package mem_access_unit_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_e;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;
  // funct3[2] is only the unsigned flag; any unlisted size code falls back to a word
  function automatic size_e acc_size(input logic [2:0] f3);
    return f3[1:0] == F3_LB[1:0] ? SZ_B : f3[1:0] == F3_LH[1:0] ? SZ_H : SZ_W;
  endfunction
endpackage

// File: rtl/mem_access_unit_align.sv
// lsu_align: byte strobes, lane-replicated store data and extended load data for one access.
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);
  size_e       sz;
  logic [1:0]  off;
  logic [15:0] sh;
  logic        sx;
  always_comb begin
    sz = acc_size(funct3);
    off = sz == SZ_B ? addr_lo : sz == SZ_H ? {addr_lo[1], 1'b0} : 2'b00;
    wstrb = sz == SZ_B ? 4'b0001 << off : sz == SZ_H ? 4'b0011 << off : 4'b1111;
    wdata = sz == SZ_B ? {4{rs2[7:0]}} : sz == SZ_H ? {2{rs2[15:0]}} : rs2;
    sh = 16'(rdata >> {off, 3'b000});
    sx = ~funct3[2];
    load_ext = sz == SZ_B ? {{24{sx & sh[7]}}, sh[7:0]} :
               sz == SZ_H ? {{16{sx & sh[15]}}, sh} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage bus controller with stall request, timeout and load buffer.
// Optional MEM_MISALIGN_TRAP_EN flags misaligned accesses instead of masking the low address bits.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_mem,
  input  logic              mem_write_mem,
  input  logic [2:0]        instr_funct3_mem,
  input  logic [ADDR_W-1:0] alu_result_mem,
  input  logic [31:0]       rs2_data_mem,
  input  logic              pipe_hold,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_wstrb,
  output logic [31:0]       dbus_wdata,
  input  logic              dbus_ready,
  input  logic [31:0]       dbus_rdata,
  output logic [31:0]       load_data_mem,
  output logic              stall_req,
  output logic              bus_timeout
`ifdef MEM_MISALIGN_TRAP_EN
  , output logic            misalign_mem
`endif
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   lbuf_q, lbuf_d, ext;
  logic          valid, go, tmo_hit;
  lsu_align u_align (
    .funct3  (instr_funct3_mem),
    .addr_lo (alu_result_mem[1:0]),
    .rs2     (rs2_data_mem),
    .rdata   (dbus_rdata),
    .wstrb   (dbus_wstrb),
    .wdata   (dbus_wdata),
    .load_ext(ext)
  );
  assign valid = mem_read_mem | mem_write_mem;
  assign dbus_we = mem_write_mem;
  assign dbus_addr = {alu_result_mem[ADDR_W-1:2], 2'b00};
`ifdef MEM_MISALIGN_TRAP_EN
  size_e sz;
  assign sz = acc_size(instr_funct3_mem);
  assign misalign_mem = valid && ((sz == SZ_H && alu_result_mem[0]) ||
                                  (sz == SZ_W && alu_result_mem[1:0] != 2'b00));
  assign go = valid & ~misalign_mem;
`else
  assign go = valid;
`endif
  assign tmo_hit = TIMEOUT_CYCLES != 0 && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lbuf_d = lbuf_q;
    dbus_req = 1'b0;
    stall_req = 1'b0;
    bus_timeout = 1'b0;
    load_data_mem = ZERO_WORD;
    case (state_q)
      S_IDLE: begin
        dbus_req = go;
        if (go && dbus_ready) begin
          load_data_mem = ext;
          lbuf_d = ext;
          state_d = pipe_hold ? S_DONE : S_IDLE;
        end else if (go) begin
          stall_req = 1'b1;
          cnt_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        dbus_req = 1'b1;
        if (dbus_ready) begin
          load_data_mem = ext;
          lbuf_d = ext;
          state_d = pipe_hold ? S_DONE : S_IDLE;
        end else if (tmo_hit) begin
          stall_req = 1'b1;
          bus_timeout = 1'b1;
          lbuf_d = ZERO_WORD;
          state_d = S_DONE;
        end else begin
          stall_req = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        load_data_mem = lbuf_q;
        state_d = pipe_hold ? S_DONE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      lbuf_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lbuf_q <= lbuf_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus multi-cycle sequences for mem_access_unit (TIMEOUT_CYCLES=4).
module tb_mem_access_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_read_mem, mem_write_mem, pipe_hold, dbus_ready;
  logic [2:0]  instr_funct3_mem;
  logic [31:0] alu_result_mem, rs2_data_mem, dbus_rdata;
  logic        dbus_req, dbus_we, stall_req, bus_timeout;
  logic [31:0] dbus_addr, dbus_wdata, load_data_mem;
  logic [3:0]  dbus_wstrb;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_mem;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .instr_funct3_mem(instr_funct3_mem), .alu_result_mem(alu_result_mem),
    .rs2_data_mem(rs2_data_mem), .pipe_hold(pipe_hold), .dbus_req(dbus_req),
    .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wstrb(dbus_wstrb),
    .dbus_wdata(dbus_wdata), .dbus_ready(dbus_ready), .dbus_rdata(dbus_rdata),
    .load_data_mem(load_data_mem), .stall_req(stall_req), .bus_timeout(bus_timeout)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_mem(misalign_mem)
`endif
  );
  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, rdata;
    logic        req, chk_ld;
    logic [31:0] daddr;
    logic [3:0]  strb;
    logic [31:0] wdata, ld;
  } vec_t;
  vec_t tv [12];
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drv(input logic rd, wr, input logic [2:0] f3, input logic [31:0] addr, rdata,
                     input logic rdy, hold);
    mem_read_mem = rd; mem_write_mem = wr; instr_funct3_mem = f3;
    alu_result_mem = addr; dbus_rdata = rdata; dbus_ready = rdy; pipe_hold = hold;
  endtask
  task automatic step;
    @(posedge clk); #1;
  endtask
  task automatic sample;
    @(negedge clk);
  endtask
  initial begin
    int stalls, reqs, hs, pulses, tpos;
    logic stable;
    tv[0]  = '{1'b0, 1'b0, 3'b000, 32'h1000, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
    tv[1]  = '{1'b1, 1'b0, 3'b000, 32'h1003, 32'h80FF_0000, 1'b1, 1'b1, 32'h1000, 4'b1000, 32'hCDCD_CDCD, 32'hFFFF_FF80};
    tv[2]  = '{1'b1, 1'b0, 3'b100, 32'h1003, 32'h80FF_0000, 1'b1, 1'b1, 32'h1000, 4'b1000, 32'hCDCD_CDCD, 32'h0000_0080};
    tv[3]  = '{1'b1, 1'b0, 3'b000, 32'h1001, 32'h80FF_7F01, 1'b1, 1'b1, 32'h1000, 4'b0010, 32'hCDCD_CDCD, 32'h0000_007F};
    tv[4]  = '{1'b1, 1'b0, 3'b001, 32'h2002, 32'h80FF_7F01, 1'b1, 1'b1, 32'h2000, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_80FF};
    tv[5]  = '{1'b1, 1'b0, 3'b101, 32'h2002, 32'h80FF_7F01, 1'b1, 1'b1, 32'h2000, 4'b1100, 32'hABCD_ABCD, 32'h0000_80FF};
    tv[6]  = '{1'b1, 1'b0, 3'b001, 32'h2000, 32'h80FF_7F01, 1'b1, 1'b1, 32'h2000, 4'b0011, 32'hABCD_ABCD, 32'h0000_7F01};
    tv[7]  = '{1'b1, 1'b0, 3'b010, 32'h3004, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h3004, 4'b1111, 32'h1234_ABCD, 32'hDEAD_BEEF};
    tv[8]  = '{1'b1, 1'b0, 3'b111, 32'h3008, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h3008, 4'b1111, 32'h1234_ABCD, 32'hCAFE_F00D};
    tv[9]  = '{1'b0, 1'b1, 3'b000, 32'h4002, 32'h0, 1'b1, 1'b0, 32'h4000, 4'b0100, 32'hCDCD_CDCD, 32'h0};
    tv[10] = '{1'b0, 1'b1, 3'b010, 32'h4000, 32'h0, 1'b1, 1'b0, 32'h4000, 4'b1111, 32'h1234_ABCD, 32'h0};
    tv[11] = '{1'b1, 1'b1, 3'b001, 32'h4000, 32'h0, 1'b1, 1'b0, 32'h4000, 4'b0011, 32'hABCD_ABCD, 32'h0};
    rs2_data_mem = 32'h1234_ABCD;
    drv(1'b0, 1'b0, 3'b000, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step(); sample();
    cmp("rst_req", dbus_req, 0);
    cmp("rst_stall", stall_req, 0);
    cmp("rst_load", load_data_mem, 0);
    cmp("rst_tmo", bus_timeout, 0);
    step(); rst = 1'b0;
    foreach (tv[i]) begin
      step();
      drv(tv[i].rd, tv[i].wr, tv[i].f3, tv[i].addr, tv[i].rdata, 1'b1, 1'b0);
      sample();
      cmp($sformatf("v%0d_req", i), dbus_req, tv[i].req);
      cmp($sformatf("v%0d_stall", i), stall_req, 0);
`ifdef MEM_MISALIGN_TRAP_EN
      cmp($sformatf("v%0d_mis", i), misalign_mem, 0);
`endif
      if (tv[i].req) begin
        cmp($sformatf("v%0d_addr", i), dbus_addr, tv[i].daddr);
        cmp($sformatf("v%0d_we", i), dbus_we, tv[i].wr);
        cmp($sformatf("v%0d_strb", i), dbus_wstrb, tv[i].strb);
        cmp($sformatf("v%0d_wdata", i), dbus_wdata, tv[i].wdata);
      end
      if (tv[i].chk_ld) cmp($sformatf("v%0d_load", i), load_data_mem, tv[i].ld);
    end
    stalls = 0; reqs = 0; stable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      drv(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0, c == 3, 1'b0);
      sample();
      stalls += int'(stall_req);
      reqs += int'(dbus_req);
      if (dbus_addr !== 32'h2000 || dbus_wstrb !== 4'b1100 || dbus_wdata !== 32'hABCD_ABCD || dbus_we !== 1'b1)
        stable = 1'b0;
    end
    cmp("sh_stalls", stalls, 3);
    cmp("sh_reqs", reqs, 4);
    cmp("sh_stable", stable, 1);
    step(); drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0); sample();
    cmp("sh_after_req", dbus_req, 0);
    cmp("sh_after_stall", stall_req, 0);
    hs = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      drv(1'b1, 1'b0, 3'b101, 32'h0, 32'h0000_F00D, 1'b1, c < 2);
      sample();
      hs += int'(dbus_req & dbus_ready);
      cmp($sformatf("lhu_c%0d_load", c), load_data_mem, 32'h0000_F00D);
      cmp($sformatf("lhu_c%0d_stall", c), stall_req, 0);
      if (c > 0) cmp($sformatf("lhu_c%0d_req", c), dbus_req, 0);
    end
    cmp("lhu_handshakes", hs, 1);
    step(); drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0000_F00D, 1'b1, 1'b0); sample();
    cmp("lhu_idle_req", dbus_req, 0);
    cmp("lhu_idle_load", load_data_mem, 0);
    stalls = 0; pulses = 0; tpos = -1;
    for (int c = 0; c < 5; c++) begin
      step();
      drv(1'b1, 1'b0, 3'b010, 32'h5000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      sample();
      stalls += int'(stall_req);
      if (bus_timeout === 1'b1) begin
        pulses++;
        if (tpos < 0) tpos = c;
      end
    end
    cmp("tmo_stalls", stalls, 5);
    cmp("tmo_pulses", pulses, 1);
    cmp("tmo_pos", tpos, 4);
    step(); sample();
    cmp("tmo_done_stall", stall_req, 0);
    cmp("tmo_done_req", dbus_req, 0);
    cmp("tmo_done_load", load_data_mem, 0);
    cmp("tmo_done_pulse", bus_timeout, 0);
    step(); drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
    pulses = 0; tpos = -1;
    for (int c = 0; c < 8; c++) begin
      step();
      rst = c == 2;
      drv(1'b1, 1'b0, 3'b010, 32'h6000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      sample();
      if (c == 3) begin
        cmp("rstw_req", dbus_req, 1);
        cmp("rstw_stall", stall_req, 1);
        cmp("rstw_tmo", bus_timeout, 0);
      end
      if (c >= 3 && bus_timeout === 1'b1) begin
        pulses++;
        if (tpos < 0) tpos = c;
      end
    end
    cmp("rstw_pulses", pulses, 1);
    cmp("rstw_pos", tpos, 7);
    step(); sample();
    cmp("rstw_done_stall", stall_req, 0);
    step(); drv(1'b1, 1'b0, 3'b101, 32'h0, 32'h0000_F00D, 1'b1, 1'b1);
    step(); rst = 1'b1; sample();
    cmp("rstd_done_req", dbus_req, 0);
    step(); rst = 1'b0; sample();
    cmp("rstd_idle_req", dbus_req, 1);
    cmp("rstd_idle_load", load_data_mem, 32'h0000_F00D);
    step(); pipe_hold = 1'b0;
    step(); drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    step(); drv(1'b1, 1'b0, 3'b010, 32'h1002, 32'h1122_3344, 1'b1, 1'b0); sample();
    cmp("mis_lw_flag", misalign_mem, 1);
    cmp("mis_lw_req", dbus_req, 0);
    cmp("mis_lw_stall", stall_req, 0);
    cmp("mis_lw_load", load_data_mem, 0);
    step(); drv(1'b1, 1'b0, 3'b001, 32'h2001, 32'h80FF_7F01, 1'b0, 1'b0); sample();
    cmp("mis_lh_flag", misalign_mem, 1);
    cmp("mis_lh_stall", stall_req, 0);
    step(); drv(1'b1, 1'b0, 3'b000, 32'h1003, 32'h80FF_0000, 1'b1, 1'b0); sample();
    cmp("mis_lb_flag", misalign_mem, 0);
    cmp("mis_lb_req", dbus_req, 1);
`else
    step(); drv(1'b1, 1'b0, 3'b010, 32'h1002, 32'h1122_3344, 1'b1, 1'b0); sample();
    cmp("mask_lw_req", dbus_req, 1);
    cmp("mask_lw_addr", dbus_addr, 32'h1000);
    cmp("mask_lw_strb", dbus_wstrb, 4'b1111);
    cmp("mask_lw_load", load_data_mem, 32'h1122_3344);
    step(); drv(1'b1, 1'b0, 3'b001, 32'h2003, 32'h80FF_7F01, 1'b1, 1'b0); sample();
    cmp("mask_lh_strb", dbus_wstrb, 4'b1100);
    cmp("mask_lh_load", load_data_mem, 32'hFFFF_80FF);
    step(); drv(1'b0, 1'b1, 3'b001, 32'h4003, 32'h0, 1'b1, 1'b0); sample();
    cmp("mask_sh_strb", dbus_wstrb, 4'b1100);
    cmp("mask_sh_wdata", dbus_wdata, 32'hABCD_ABCD);
`endif
    step(); drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
